// File: rtl/nmx1_pkg.sv
// Shared definitions for the nmx1 Wishbone-to-ReRAM-macro bridge:
// FSM states, register offsets, STATUS bit positions and DI field layout.
package nmx1_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  // Register offsets, selected by wb_adr_i[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_UNMAP  = 2'd3;

  // STATUS register layout
  localparam int ST_OCC_LSB  = 0;
  localparam int ST_OCC_MSB  = 5;
  localparam int ST_BUSY_BIT = 8;
  localparam int ST_FULL_BIT = 9;
  localparam int ST_EMPT_BIT = 10;
  localparam int ST_TMO_BIT  = 11;

  // Macro write word layout
  localparam int DI_ROW_MSB  = 29;
  localparam int DI_ROW_LSB  = 25;
  localparam int DI_COL_MSB  = 24;
  localparam int DI_COL_LSB  = 20;
  localparam int DI_DATA_MSB = 7;
  localparam int DI_DATA_LSB = 0;

  // Build a macro write word from row, column and data byte
  function automatic logic [31:0] make_di(input logic [4:0] row,
                                          input logic [4:0] col,
                                          input logic [7:0] data);
    logic [31:0] w;
    w = '0;
    w[DI_ROW_MSB:DI_ROW_LSB]   = row;
    w[DI_COL_MSB:DI_COL_LSB]   = col;
    w[DI_DATA_MSB:DI_DATA_LSB] = data;
    return w;
  endfunction

endpackage

// File: rtl/nmx1_txn_timer.sv
// Loadable down-counter with clear and enable. done_o is high while the
// count is zero; the bridge uses it for both the request timeout and the
// post-transaction EN gap.
module nmx1_txn_timer
  import nmx1_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         CLKin,
  input  logic         RSTin,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over clear, clear wins over decrement; stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/nmx1_wb_bridge.sv
// Wishbone classic slave in front of the 32x32 ReRAM neuromorphic macro.
// DATA accesses become EN/R_WB/DI/AD/SEL macro requests completed by
// func_ack; STATUS/CTRL are local. Occupancy of the macro queue is tracked
// so writes to a full queue and reads from an empty one error out at once.
//
// Bus handshake: a request is wb_cyc_i & wb_stb_i & address hit, sampled
// only in IDLE. Each request gets exactly one single-cycle wb_ack_o or
// wb_err_o (never both); the master keeps cyc/stb high until it sees one.
// The request is masked while this cycle's ack/err is still showing so a
// master dropping stb on the response cannot be counted twice.
module nmx1_wb_bridge
  import nmx1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFF0,
  parameter int          DEPTH       = 32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          GAP_CYC     = 2
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] DI,
  output logic [31:0] AD,
  output logic [3:0]  SEL,
  input  logic [31:0] DO,
  input  logic        func_ack,
  output logic        busy_o
);

  localparam int          TW       = 11;
  localparam logic [5:0]  DEPTH_C  = 6'(DEPTH);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic        r_wb_q, r_wb_d;
  logic [31:0] di_q, di_d;
  logic [31:0] ad_q, ad_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] stat_q, stat_d;
  logic        stat_rd_q, stat_rd_d;
  logic [5:0]  occ_q, occ_d;
  logic        tmo_q, tmo_d;
  logic        drop_q, drop_d;

  logic        tmr_load, tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0] tmr_val;

  logic        hit, req, full, empty, busy, cyc_lost;
  logic [31:0] status_w;

  assign hit      = ((wb_adr_i & ADDR_MASK) == BASE_ADDR);
  assign req      = wb_cyc_i & wb_stb_i & hit & ~ack_q & ~err_q;
  assign full     = (occ_q == DEPTH_C);
  assign empty    = (occ_q == 6'd0);
  assign busy     = (state_q != IDLE);
  assign cyc_lost = drop_q | ~wb_cyc_i;

  // Assemble the STATUS word from live state
  always_comb begin
    status_w                         = '0;
    status_w[ST_OCC_MSB:ST_OCC_LSB]  = occ_q;
    status_w[ST_BUSY_BIT]            = busy;
    status_w[ST_FULL_BIT]            = full;
    status_w[ST_EMPT_BIT]            = empty;
    status_w[ST_TMO_BIT]             = tmo_q;
  end

  nmx1_txn_timer #(.W(TW)) u_timer (
    .CLKin      (CLKin),
    .RSTin      (RSTin),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // Bridge FSM: next state, macro request fields, bus responses, occupancy
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    r_wb_d    = r_wb_q;
    di_d      = di_q;
    ad_d      = ad_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = rdat_q;
    stat_d    = stat_q;
    stat_rd_d = 1'b0;
    occ_d     = occ_q;
    tmo_d     = tmo_q;
    drop_d    = drop_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (req) begin
          unique case (wb_adr_i[3:2])
            REG_DATA: begin
              if ((wb_we_i && full) || (!wb_we_i && empty)) begin
                err_d = 1'b1;
              end else begin
                di_d     = wb_dat_i;
                ad_d     = wb_adr_i;
                sel_d    = wb_sel_i;
                r_wb_d   = ~wb_we_i;
                en_d     = 1'b1;
                drop_d   = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = TMO_LOAD;
                state_d  = ISSUE;
              end
            end
            REG_STATUS: begin
              if (wb_we_i) begin
                err_d = 1'b1;
              end else begin
                stat_d    = status_w;
                stat_rd_d = 1'b1;
                ack_d     = 1'b1;
              end
            end
            REG_CTRL: begin
              if (wb_we_i) begin
                if (wb_dat_i[0]) tmo_d = 1'b0;
                ack_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            REG_UNMAP: err_d = 1'b1;
            default:   err_d = 1'b1;
          endcase
        end
      end

      ISSUE: begin
        if (r_wb_q && !wb_cyc_i) begin
          // Master gave up on a read: the macro abandons it when EN drops
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = RECOVER;
        end else if (func_ack) begin
          if (r_wb_q) begin
            rdat_d = DO;
            if (!empty) occ_d = occ_q - 6'd1;
          end else begin
            if (!full) occ_d = occ_q + 6'd1;
          end
          en_d     = 1'b0;
          ack_d    = ~cyc_lost;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = RECOVER;
        end else if (tmr_done) begin
          en_d     = 1'b0;
          err_d    = ~cyc_lost;
          tmo_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = RECOVER;
        end else begin
          tmr_en = 1'b1;
          // A write keeps going after the master leaves; only its ack is lost
          if (!wb_cyc_i) drop_d = 1'b1;
        end
      end

      RECOVER: begin
        if (tmr_done) state_d = IDLE;
        else          tmr_en  = 1'b1;
      end

      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      r_wb_q    <= 1'b1;
      di_q      <= '0;
      ad_q      <= '0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdat_q    <= '0;
      stat_q    <= '0;
      stat_rd_q <= 1'b0;
      occ_q     <= '0;
      tmo_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      r_wb_q    <= r_wb_d;
      di_q      <= di_d;
      ad_q      <= ad_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdat_q    <= rdat_d;
      stat_q    <= stat_d;
      stat_rd_q <= stat_rd_d;
      occ_q     <= occ_d;
      tmo_q     <= tmo_d;
      drop_q    <= drop_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  // STATUS data shows only during its ack; otherwise the last DATA read holds
  assign wb_dat_o = stat_rd_q ? stat_q : rdat_q;
  assign EN       = en_q;
  assign R_WB     = r_wb_q;
  assign DI       = di_q;
  assign AD       = ad_q;
  assign SEL      = sel_q;
  assign busy_o   = busy;

endmodule

// File: tb/tb_nmx1_wb_bridge.sv
// Directed bench for nmx1_wb_bridge with a behavioural macro model.
module tb_nmx1_wb_bridge;
  import nmx1_pkg::*;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam int          RD_DLY = 44;

  logic        CLKin = 1'b0;
  logic        RSTin = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic        EN, R_WB;
  logic [31:0] DI, AD;
  logic [3:0]  SEL;
  logic [31:0] DO;
  logic        func_ack;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic ack_en = 1'b1;

  logic [31:0] exp_q[$];     // expected DATA read words
  logic [31:0] di_exp_q[$];  // expected macro write words
  logic [7:0]  mem_q[$];     // macro model storage
  logic        m_active, m_done;
  int          m_cnt;

  nmx1_wb_bridge dut (
    .CLKin(CLKin), .RSTin(RSTin),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .EN(EN), .R_WB(R_WB), .DI(DI), .AD(AD), .SEL(SEL),
    .DO(DO), .func_ack(func_ack), .busy_o(busy_o)
  );

  // Clock
  always #5 CLKin = ~CLKin;

  // EN activity counter
  always @(posedge CLKin) if (EN) en_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Macro model: writes complete in the first EN cycle, reads RD_DLY-1 later
  always @(negedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      func_ack <= 1'b0;
      DO       <= '0;
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_cnt    <= 0;
    end else begin
      func_ack <= 1'b0;
      if (!EN) begin
        m_active <= 1'b0;
        m_done   <= 1'b0;
      end else if (!m_active) begin
        m_active <= 1'b1;
        if (!R_WB) begin
          if (ack_en) begin
            func_ack <= 1'b1;
            m_done   <= 1'b1;
            mem_q.push_back(DI[7:0]);
            if (di_exp_q.size() != 0) begin
              check("macro_di", DI, di_exp_q.pop_front());
              check("macro_ad", AD, A_DATA);
              check("macro_sel", {28'h0, SEL}, 32'hF);
            end else begin
              checks++;
              errors++;
              $display("FAIL macro_write: observed unexpected write %h required none", DI);
            end
          end
        end else begin
          m_cnt <= RD_DLY - 1;
        end
      end else if (R_WB && !m_done) begin
        if (m_cnt == 0) begin
          func_ack <= 1'b1;
          m_done   <= 1'b1;
          DO       <= {24'h0, mem_q.pop_front()};
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLKin);
    #1;
  endtask

  // One bus access; lat = clock edges from request presentation to response
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic ack, output logic err, output logic [31:0] rdata,
                         output int lat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = 4'hF;
    ack = 1'b0; err = 1'b0; rdata = '0; lat = 0;
    while (lat < 2000) begin
      @(posedge CLKin);
      #1;
      lat++;
      if (wb_ack_o || wb_err_o) begin
        ack = wb_ack_o; err = wb_err_o; rdata = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!ack && !err) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: observed no response required ack or err");
    end
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    logic a, e;
    logic [31:0] d;
    int l;
    wb_xfer(1'b0, A_STAT, '0, a, e, d, l);
    check({tag, "_ack"}, {31'h0, a}, 32'h1);
    check({tag, "_lat"}, l, 32'd1);
    check(tag, d, exp);
    idle(2);
  endtask

  logic        ack, err;
  logic [31:0] rd, di;
  int          lat, en0, resp;

  initial begin
    // Reset
    repeat (3) @(posedge CLKin);
    #1;
    check("rst_en", {31'h0, EN}, 32'h0);
    check("rst_rwb", {31'h0, R_WB}, 32'h1);
    check("rst_di", DI, 32'h0);
    check("rst_ad", AD, 32'h0);
    check("rst_ack_err", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    RSTin = 1'b1;
    idle(2);
    read_status("status_reset", 32'h400);

    // DATA read from empty queue
    en0 = en_cnt;
    wb_xfer(1'b0, A_DATA, '0, ack, err, rd, lat);
    check("rd_empty_err", {30'h0, ack, err}, 32'h1);
    check("rd_empty_lat", lat, 32'd1);
    idle(4);
    check("rd_empty_no_en", en_cnt, en0);

    // Unmapped offset
    wb_xfer(1'b0, BASE + 32'hC, '0, ack, err, rd, lat);
    check("unmapped_err", {30'h0, ack, err}, 32'h1);
    idle(2);

    // Macro write of A5 at row 2 column 2
    di = make_di(5'd2, 5'd2, 8'hA5);
    di_exp_q.push_back(32'h0420_00A5);
    wb_xfer(1'b1, A_DATA, di, ack, err, rd, lat);
    check("wr_ack", {30'h0, ack, err}, 32'h2);
    check("wr_lat", lat, 32'd2);
    idle(4);
    read_status("status_after_wr", 32'h1);

    // Macro read back
    exp_q.push_back(32'h0000_00A5);
    wb_xfer(1'b0, A_DATA, '0, ack, err, rd, lat);
    check("rd_ack", {30'h0, ack, err}, 32'h2);
    check("rd_lat", lat, 32'd46);
    check("rd_data", rd, exp_q.pop_front());
    idle(4);
    check("rd_data_hold", wb_dat_o, 32'h0000_00A5);
    read_status("status_after_rd", 32'h400);

    // Timeout with a silent macro
    ack_en = 1'b0;
    wb_xfer(1'b1, A_DATA, 32'h1234_0011, ack, err, rd, lat);
    check("tmo_err", {30'h0, ack, err}, 32'h1);
    check("tmo_lat", lat, 32'd1025);
    @(posedge CLKin);
    #1;
    check("tmo_en_low", {31'h0, EN}, 32'h0);
    idle(4);
    ack_en = 1'b1;
    read_status("status_tmo", 32'hC00);
    wb_xfer(1'b1, A_CTRL, 32'h1, ack, err, rd, lat);
    check("ctrl_ack", {30'h0, ack, err}, 32'h2);
    check("ctrl_lat", lat, 32'd1);
    idle(2);
    read_status("status_tmo_clr", 32'h400);

    // Fill the queue
    for (int i = 0; i < 32; i++) begin
      di = make_di(5'(i), 5'(31 - i), 8'($urandom_range(0, 255)));
      di_exp_q.push_back(di);
      wb_xfer(1'b1, A_DATA, di, ack, err, rd, lat);
      check("fill_ack", {30'h0, ack, err}, 32'h2);
      check("fill_lat", lat, 32'd2);
      idle(4);
    end
    read_status("status_full", 32'h220);

    // 33rd write is refused without touching the macro
    en0 = en_cnt;
    wb_xfer(1'b1, A_DATA, 32'h0000_0077, ack, err, rd, lat);
    check("full_err", {30'h0, ack, err}, 32'h1);
    check("full_lat", lat, 32'd1);
    idle(4);
    check("full_no_en", en_cnt, en0);
    read_status("status_still_full", 32'h220);

    // Read abandoned by the master after 10 cycles
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_DATA; wb_sel_i = 4'hF;
    resp = 0;
    repeat (10) begin
      @(posedge CLKin);
      #1;
      if (wb_ack_o || wb_err_o) resp++;
    end
    check("drop_en_before", {31'h0, EN}, 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge CLKin);
    #1;
    check("drop_en_low", {31'h0, EN}, 32'h0);
    repeat (60) begin
      @(posedge CLKin);
      #1;
      if (wb_ack_o || wb_err_o) resp++;
    end
    check("drop_no_resp", resp, 32'd0);
    read_status("status_after_drop", 32'h220);

    // Asynchronous reset in the middle of a read
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_DATA;
    repeat (5) @(posedge CLKin);
    #1;
    check("midrd_busy", {31'h0, busy_o}, 32'h1);
    #3;
    RSTin = 1'b0;
    #1;
    check("arst_en", {31'h0, EN}, 32'h0);
    check("arst_rwb", {31'h0, R_WB}, 32'h1);
    check("arst_di", DI, 32'h0);
    check("arst_ad", AD, 32'h0);
    check("arst_sel", {28'h0, SEL}, 32'h0);
    check("arst_ack_err", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
    check("arst_dat", wb_dat_o, 32'h0);
    check("arst_busy", {31'h0, busy_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge CLKin);
    #1;
    RSTin = 1'b1;
    idle(2);
    read_status("status_after_arst", 32'h400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmx1_wb_bridge.md
Name: nmx1_wb_bridge

Overview:
- Wishbone classic slave that sits directly upstream of the 32x32 ReRAM neuromorphic macro.
- Translates bus cycles into the macro's EN/R_WB/DI/AD/SEL request protocol and waits for func_ack. Returns read data and tracks macro queue occupancy.
- Rejects writes to a full queue and reads from an empty one with wb_err_o, so the bus never hangs.
- A timeout guards every issued request.

Parameters:
- BASE_ADDR, 32'h3000_0000: bridge base address.
- ADDR_MASK, 32'hFFFF_FFF0: bits compared against BASE_ADDR for the select.
- DEPTH, 32: macro queue capacity.
- TIMEOUT_CYC, 1024: maximum ISSUE cycles before abort.
- GAP_CYC, 2: cycles EN is forced low after each macro transaction.

Ports:
- CLKin  in  1  clock
- RSTin  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte select
- wb_ack_o  out  1  one-cycle acknowledge
- wb_err_o  out  1  one-cycle error
- wb_dat_o  out  32  read data
- EN  out  1  macro request
- R_WB  out  1  1 = read, 0 = write
- DI  out  32  macro write word; bits 29:25 = row, 24:20 = column, 7:0 = data
- AD  out  32  macro address (copy of wb_adr_i)
- SEL  out  4  byte select to the macro
- DO  in  32  macro read data
- func_ack  in  1  macro acknowledge pulse
- busy_o  out  1  high in every state other than IDLE

Behaviour:
- Reset values: EN=0, R_WB=1, DI=0, AD=0, SEL=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0, occupancy=0, timeout sticky=0, state=IDLE.
- Reset mid-operation aborts immediately to these values. No ack is generated.
- Address map (wb_adr_i[3:2], valid only when (wb_adr_i & ADDR_MASK) == BASE_ADDR):
  - 0 DATA (R/W): write = macro write; read = macro read.
  - 1 STATUS (RO): [5:0] occupancy, [8] busy, [9] full, [10] empty, [11] timeout sticky.
  - 2 CTRL (W): bit0 = 1 clears timeout sticky.
  - 3: unmapped; responds wb_err_o.
- A request is cyc & stb & select, sampled in IDLE. wb_ack_o and wb_err_o are each high for exactly one cycle per request, never together.
- STATUS, CTRL and unmapped accesses: ack or err is registered at the edge after the request (latency 1). No macro activity.
- DATA write with occupancy == DEPTH, or DATA read with occupancy == 0: wb_err_o at latency 1, EN never raised.
- State IDLE: on a valid DATA request, register DI/AD/SEL/R_WB = !wb_we_i, set EN=1, clear the timer, go to ISSUE.
- State ISSUE: EN held high.
  - func_ack=1:
    - Read: wb_dat_o <= DO, occupancy--.
    - Write: occupancy++.
    - Then EN <= 0, wb_ack_o <= 1, go to RECOVER.
  - Timer reaches TIMEOUT_CYC-1: EN <= 0, wb_err_o <= 1, timeout sticky set, occupancy unchanged, go to RECOVER.
  - wb_cyc_i dropped during a read: EN <= 0, no ack, occupancy unchanged, go to RECOVER (the macro abandons the read).
  - wb_cyc_i dropped during a write: keep waiting for func_ack. Count the write but suppress wb_ack_o.
- State RECOVER: EN=0 for GAP_CYC cycles, then IDLE.
  - New requests are not sampled; the bus is stalled, with no ack.
  - The macro may stall after writes while EN is low. ISSUE tolerates this through the timeout only.
- Latency:
  - Macro write: wb_ack_o is high 2 cycles after the request edge.
  - Macro read: wb_ack_o is high RD_Dly+2 cycles after the request edge, which is 46 with macro RD_Dly=44.
- Occupancy is 6-bit, saturating 0..DEPTH, and is never incremented and decremented in the same cycle.
- A func_ack seen outside ISSUE is ignored.
- wb_dat_o holds until the next successful DATA read.

Decomposition:
- Package nmx1_pkg holds:
  - the state enum (IDLE, ISSUE, RECOVER);
  - register offsets;
  - STATUS bit positions;
  - DI field positions (row 29:25, column 24:20, data 7:0).
- One sub-module, nmx1_txn_timer: a loadable counter with clear/enable and a terminal flag. It is used for both the timeout and the GAP_CYC countdown.

Test Plan:
- Write DATA with wb_dat_i=32'h0420_00A5 (row 2, column 2, data A5) → EN high 1+ cycles with DI=32'h0420_00A5 and R_WB=0. wb_ack_o 2 cycles after the request. STATUS reads 32'h1 (occupancy 1).
- After the write above, read DATA → wb_ack_o at cycle 46, wb_dat_o=32'h0000_00A5, STATUS occupancy 0, empty bit 10 set.
- Read DATA after reset → wb_err_o at latency 1. EN stays 0 throughout.
- 32 writes then a 33rd → the 33rd gets wb_err_o, EN not raised. STATUS = 32'h220 (occupancy 32, full).
- Macro model with func_ack tied 0, write DATA → wb_err_o after 1024 ISSUE cycles, then EN low. STATUS bit 11 = 1. Writing CTRL=1 clears bit 11.
- Read in flight with wb_cyc_i dropped at cycle 10 → EN low next cycle, no ack, occupancy unchanged. RSTin pulsed mid-read → all outputs at reset values asynchronously.
